muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit.sv | 146 ++++++++++++++
 tb/tb_muldiv_unit.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: HI/LO multiply/divide unit for the EX stage.
// Multiplies take 5 busy cycles and divides take 10; mthi/mtlo write in one
// edge. The operands are captured when a command is accepted, and the result
// is written to HI/LO at the edge that ends the last busy cycle.
module muldiv_unit (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        flush,
  input  logic        hilo_sel,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] md_rdata,
  output logic        state_dbg
);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t      state, state_next;
  logic [3:0]  cnt, cnt_next;
  logic [2:0]  op_q;
  logic [31:0] a_q, b_q;
  logic        accept;
  logic        finish;
  logic        sdiv;
  logic [63:0] prod_s, prod_u;
  logic [31:0] a_mag, b_mag, b_div, q_mag, r_mag, quot, rem;

  // Handshake: start is a single-cycle issue strobe with no ready signal.
  // A command is taken on an edge only if the unit is IDLE, start=1, flush=0
  // and op is not reserved (110/111). Otherwise it is silently dropped.
  // busy=1 means a mult/div is in flight and any start is ignored.
  always_comb begin
    accept = (state == IDLE) && start && !flush && (op <= OP_MTLO);
    finish = (state == BUSY) && (cnt == 4'd0);
  end

  // Next-state logic. cnt holds the number of busy cycles left after the
  // current one.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (accept && !op[2]) begin
          state_next = BUSY;
          cnt_next   = op[1] ? 4'd9 : 4'd4;
        end
      end
      BUSY: begin
        if (cnt == 4'd0) state_next = IDLE;
        else             cnt_next   = cnt - 4'd1;
      end
      default: begin
        state_next = IDLE;
        cnt_next   = 4'd0;
      end
    endcase
  end

  // State, counter and busy registers. busy is registered so that it leaves
  // the block straight from a flop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= 4'd0;
      busy  <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      busy  <= (state_next == BUSY);
    end
  end

  // Operand capture on acceptance. Later changes on A, B and op have no effect.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_q <= 3'd0;
      a_q  <= 32'd0;
      b_q  <= 32'd0;
    end else if (accept && !op[2]) begin
      op_q <= op;
      a_q  <= A;
      b_q  <= B;
    end
  end

  // Arithmetic on the captured operands. A signed divide is done on the
  // magnitudes, and the signs are applied afterwards. This gives
  // 0x80000000 / -1 = 0x80000000 with a remainder of 0.
  always_comb begin
    sdiv   = (op_q == OP_DIV);
    prod_s = 64'($signed(a_q)) * 64'($signed(b_q));
    prod_u = {32'd0, a_q} * {32'd0, b_q};
    a_mag  = (sdiv && a_q[31]) ? (32'd0 - a_q) : a_q;
    b_mag  = (sdiv && b_q[31]) ? (32'd0 - b_q) : b_q;
    b_div  = (b_mag == 32'd0) ? 32'd1 : b_mag;
    q_mag  = a_mag / b_div;
    r_mag  = a_mag % b_div;
    quot   = (sdiv && (a_q[31] ^ b_q[31])) ? (32'd0 - q_mag) : q_mag;
    rem    = (sdiv && a_q[31]) ? (32'd0 - r_mag) : r_mag;
  end

  // HI/LO writes. mthi/mtlo write at the accepting edge. A mult/div writes at
  // the edge that ends its last busy cycle. A divide by zero writes nothing.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      HI <= 32'd0;
      LO <= 32'd0;
    end else if (accept && op == OP_MTHI) begin
      HI <= A;
    end else if (accept && op == OP_MTLO) begin
      LO <= A;
    end else if (finish) begin
      case (op_q)
        OP_MULT:  {HI, LO} <= prod_s;
        OP_MULTU: {HI, LO} <= prod_u;
        OP_DIV, OP_DIVU: begin
          if (b_q != 32'd0) begin
            HI <= rem;
            LO <= quot;
          end
        end
        default: ;
      endcase
    end
  end

  // Read port for mfhi/mflo, plus a state view for debug.
  always_comb begin
    md_rdata  = hilo_sel ? HI : LO;
    state_dbg = (state == BUSY);
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: random and directed stimulus for muldiv_unit. Expected
// HI/LO values come from a plain-arithmetic reference model. A monitor checks
// each mult/div completion against an expected queue.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        flush;
  logic        hilo_sel;
  logic        busy;
  logic [31:0] hi, lo, md_rdata;
  logic        state_dbg;

  int checks = 0;
  int errors = 0;
  int run_len = 0;

  // Each entry is {HI, LO, busy length}.
  logic [67:0] exp_q[$];
  logic [31:0] m_hi, m_lo;

  muldiv_unit dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op), .A(a), .B(b),
    .flush(flush), .hilo_sel(hilo_sel), .busy(busy), .HI(hi), .LO(lo),
    .md_rdata(md_rdata), .state_dbg(state_dbg)
  );

  // ---------------------------------------------------------------- clock
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- helpers
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%08h required=%08h", name, act, req);
    end
  endtask

  // Reference model. It returns {HI, LO, busy cycles} from the arithmetic
  // rules, given the previous HI/LO values.
  function automatic logic [67:0] model(input logic [2:0] o, input logic [31:0] x,
                                        input logic [31:0] y, input logic [31:0] h,
                                        input logic [31:0] l);
    longint sx, sy, q, r;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      3'd0: begin p = 64'(sx * sy); return {p, 4'd5}; end
      3'd1: begin p = {32'd0, x} * {32'd0, y}; return {p, 4'd5}; end
      3'd2: begin
        if (y == 32'd0) return {h, l, 4'd10};
        q = sx / sy;
        r = sx % sy;
        return {r[31:0], q[31:0], 4'd10};
      end
      default: begin
        if (y == 32'd0) return {h, l, 4'd10};
        return {x % y, x / y, 4'd10};
      end
    endcase
  endfunction

  // ---------------------------------------------------------------- monitor
  // Counts busy cycles. When busy falls, it pops the expected entry and checks
  // the busy length, HI, LO and md_rdata.
  always @(negedge clk) begin
    logic [67:0] e;
    if (!reset_n) begin
      exp_q.delete();
      run_len = 0;
    end else if (busy) begin
      run_len++;
    end else if (run_len != 0) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_completion actual=1 required=0");
      end else begin
        e = exp_q.pop_front();
        chk("busy_len", 32'(run_len), 32'(e[3:0]));
        chk("result_hi", hi, e[67:36]);
        chk("result_lo", lo, e[35:4]);
        chk("md_rdata", md_rdata, hilo_sel ? e[67:36] : e[35:4]);
      end
      run_len = 0;
    end
  end

  // ---------------------------------------------------------------- drivers
  // All driver tasks are entered at a negedge and return at a negedge.
  // mode 0: quiet, 1: start and A/B/op toggling during busy, 2: flush held.
  task automatic do_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       input int mode);
    logic [67:0] e;
    int n;
    e = model(o, x, y, m_hi, m_lo);
    hilo_sel = 1'($urandom_range(0, 1));
    start = 1'b1; op = o; a = x; b = y; flush = 1'b0;
    @(negedge clk);
    start = 1'b0;
    exp_q.push_back(e);
    chk("busy_after_accept", 32'(busy), 32'd1);
    chk("pre_hi", hi, m_hi);
    chk("pre_lo", lo, m_lo);
    n = 0;
    while (busy === 1'b1 && n < 20) begin
      if (mode == 1) begin
        start = (n >= 1);
        a = $urandom; b = $urandom; op = 3'($urandom_range(0, 5));
      end else if (mode == 2) begin
        flush = 1'b1;
        a = $urandom; b = $urandom;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    flush = 1'b0;
    if (n >= 20) begin
      checks++;
      errors++;
      $display("FAIL busy_timeout actual=%0d required=<20", n);
    end
    m_hi = e[67:36];
    m_lo = e[35:4];
  endtask

  task automatic do_mt(input logic hi_not_lo, input logic [31:0] x);
    start = 1'b1; op = hi_not_lo ? 3'd4 : 3'd5; a = x; flush = 1'b0;
    @(negedge clk);
    start = 1'b0;
    if (hi_not_lo) m_hi = x; else m_lo = x;
    chk("mt_busy", 32'(busy), 32'd0);
    chk("mt_hi", hi, m_hi);
    chk("mt_lo", lo, m_lo);
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    logic [2:0] ro;
    logic [31:0] rx, ry;
    reset_n = 1'b0; start = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0;
    flush = 1'b0; hilo_sel = 1'b0;
    m_hi = 32'd0; m_lo = 32'd0;
    repeat (3) @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);

    // The command is taken on the first rising edge after reset is released.
    reset_n = 1'b1;
    do_mt(1'b1, 32'hCAFE0001);

    // Directed arithmetic cases.
    do_op(3'd0, 32'hFFFFFFFE, 32'd3, 0);
    chk("mult_hi", m_hi, 32'hFFFFFFFF);
    do_op(3'd1, 32'hFFFFFFFE, 32'd3, 0);
    do_op(3'd2, 32'hFFFFFFF9, 32'd2, 0);
    do_op(3'd3, 32'd7, 32'd0, 0);
    do_op(3'd2, 32'h80000000, 32'hFFFFFFFF, 0);
    do_op(3'd0, 32'h12345678, 32'h87654321, 1);
    do_op(3'd2, 32'h00001234, 32'hFFFFFFF0, 2);
    // A new command is accepted in the first cycle that busy is low.
    do_op(3'd3, 32'hFFFFFFFF, 32'd16, 0);

    // mthi and mtlo issued back to back.
    do_mt(1'b1, 32'h12345678);
    do_mt(1'b0, 32'h9ABCDEF0);
    hilo_sel = 1'b1;
    #1 chk("rdata_hi", md_rdata, 32'h12345678);
    hilo_sel = 1'b0;
    #1 chk("rdata_lo", md_rdata, 32'h9ABCDEF0);
    @(negedge clk);

    // start with flush high, and a reserved op code.
    start = 1'b1; flush = 1'b1; op = 3'd0; a = 32'd5; b = 32'd6;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    chk("flush_busy", 32'(busy), 32'd0);
    start = 1'b1; op = 3'd6; a = 32'hDEAD0000;
    @(negedge clk);
    start = 1'b1; op = 3'd7;
    @(negedge clk);
    start = 1'b0;
    chk("reserved_busy", 32'(busy), 32'd0);
    chk("reserved_hi", hi, m_hi);
    chk("reserved_lo", lo, m_lo);

    // Random operations.
    for (int i = 0; i < 40; i++) begin
      ro = 3'($urandom_range(0, 5));
      rx = $urandom;
      ry = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) ry = ry >> $urandom_range(8, 28);
      if (ro >= 3'd4) do_mt(ro == 3'd4, rx);
      else            do_op(ro, rx, ry, int'($urandom_range(0, 2)));
    end

    // Reset asserted in busy cycle 4 of a divide.
    start = 1'b1; op = 3'd2; a = 32'h00000064; b = 32'd5; flush = 1'b0;
    @(negedge clk);
    start = 1'b0;
    exp_q.push_back(model(3'd2, 32'h64, 32'd5, m_hi, m_lo));
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_hi", hi, 32'd0);
    chk("async_rst_lo", lo, 32'd0);
    m_hi = 32'd0; m_lo = 32'd0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (15) @(negedge clk);
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_hi", hi, 32'd0);
    chk("post_rst_lo", lo, 32'd0);

    do_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
    @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Overall time limit so the run always ends.
  initial begin
    #500000;
    checks++;
    errors++;
    $display("FAIL global_timeout actual=expired required=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
